// File: rtl/data_memory.sv
// Byte-addressable data memory for the MIPS MEM stage: sized, sign/zero-extended
// loads and lane-masked stores behind a req/ready/valid handshake with configurable latency.
module data_memory #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [1:0]       size_i,
    input  logic             unsigned_i,
    input  logic [31:0]      addr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             err_o
);

    localparam int LANES = WIDTH / 8;
    localparam int OFS   = $clog2(LANES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Lanes touched by an access of the given size, before shifting to the addressed lane.
    function automatic logic [LANES-1:0] size_mask(input logic [1:0] size);
        logic [LANES-1:0] m;
        case (size)
            2'b00:   m = LANES'(8'h01);
            2'b01:   m = LANES'(8'h03);
            2'b10:   m = LANES'(8'h0F);
            2'b11:   m = {LANES{1'b1}};
            default: m = '0;
        endcase
        return m;
    endfunction

    // Keep the low 1/2/4/8 bytes and fill the rest with the sign bit or zeros.
    function automatic logic [WIDTH-1:0] extend_load(input logic [WIDTH-1:0] v,
                                                     input logic [1:0]       size,
                                                     input logic             uns);
        logic [WIDTH-1:0] keep;
        logic             sign;
        int               nbytes;
        nbytes = int'(32'd1 << size);
        nbytes = (nbytes > LANES) ? LANES : nbytes;
        keep   = '0;
        for (int i = 0; i < LANES; i++) begin
            keep[8*i +: 8] = (i < nbytes) ? 8'hFF : 8'h00;
        end
        sign = v[8*nbytes-1] & ~uns;
        return (v & keep) | ({WIDTH{sign}} & ~keep);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] pend_data_q, pend_data_d;
    logic             pend_err_q, pend_err_d;

    logic [OFS-1:0]   lane_s;
    logic [31:0]      idx_full_s;
    logic [IDX_W-1:0] idx_s;
    logic             in_range_s;
    logic             misalign_s;
    logic             err_s;
    logic             accept_s;
    logic             mem_we_s;
    logic [WIDTH-1:0] rword_s;
    logic [WIDTH-1:0] load_s;
    logic [LANES-1:0] be_s;
    logic [WIDTH-1:0] wdata_s;

    // Address decode, error classification and lane steering for the current request.
    always_comb begin
        lane_s     = addr_i[OFS-1:0];
        idx_full_s = addr_i >> OFS;
        in_range_s = (idx_full_s < 32'(DEPTH));
        idx_s      = idx_full_s[IDX_W-1:0];
        case (size_i)
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = lane_s[0];
            2'b10:   misalign_s = (lane_s[1:0] != 2'b00);
            2'b11:   misalign_s = (WIDTH < 64) ? 1'b1 : (lane_s != '0);
            default: misalign_s = 1'b1;
        endcase
        err_s    = misalign_s | ~in_range_s;
        accept_s = req_i & ready_q;
        mem_we_s = accept_s & we_i & ~err_s;
        rword_s  = in_range_s ? mem[idx_s] : '0;
        load_s   = extend_load(rword_s >> {lane_s, 3'b000}, size_i, unsigned_i);
        be_s     = size_mask(size_i) << lane_s;
        wdata_s  = data_i << {lane_s, 3'b000};
    end

    // Store commits on its acceptance edge; contents are deliberately outside reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int l = 0; l < LANES; l++) begin
                if (be_s[l]) begin
                    mem[idx_s][8*l +: 8] <= wdata_s[8*l +: 8];
                end
            end
        end
    end

    // Next-state, wait counter, captured response and registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_data_d = pend_data_q;
        pend_err_d  = pend_err_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept_s) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_RESP;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        // Stores and rejected accesses answer with zero data.
        if (accept_s) begin
            pend_err_d  = err_s;
            pend_data_d = (err_s || we_i) ? '0 : load_s;
        end else begin
            pend_err_d  = pend_err_q;
            pend_data_d = pend_data_q;
        end

        ready_d = (state_d != S_WAIT);
        valid_d = (state_q == S_RESP);
        if (state_q == S_RESP) begin
            data_d = pend_data_q;
            err_d  = pend_err_q;
        end else begin
            data_d = data_q;
            err_d  = err_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
            pend_data_q <= '0;
            pend_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            err_q       <= err_d;
            pend_data_q <= pend_data_d;
            pend_err_q  <= pend_err_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a zero-wait instance and a three-wait-state instance.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req3, we, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdat;
    logic        ready0, valid0, err0;
    logic [31:0] data0;
    logic        ready3, valid3, err3;
    logic [31:0] data3;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    data_memory #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .we_i(we), .size_i(sz),
        .unsigned_i(uns), .addr_i(addr), .data_i(wdat),
        .ready_o(ready0), .valid_o(valid0), .data_o(data0), .err_o(err0)
    );

    data_memory #(.WIDTH(32), .DEPTH(1024), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .we_i(we), .size_i(sz),
        .unsigned_i(uns), .addr_i(addr), .data_i(wdat),
        .ready_o(ready3), .valid_o(valid3), .data_o(data3), .err_o(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated access on the zero-wait instance; response expected one cycle later.
    task automatic acc0(input string tag, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee);
        @(negedge clk);
        we = w; sz = s; uns = u; addr = a; wdat = d; req0 = 1'b1;
        chk({tag, "_ready"}, 32'(ready0), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        chk({tag, "_novalid"}, 32'(valid0), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(valid0), 32'd1);
        chk({tag, "_data"}, data0, ed);
        chk({tag, "_err"}, 32'(err0), 32'(ee));
    endtask

    // One access on the wait-state instance with a bounded wait for valid_o.
    task automatic acc3(input string tag, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ed, input logic ee);
        int n;
        @(negedge clk);
        we = w; sz = s; uns = u; addr = a; wdat = d; req3 = 1'b1;
        chk({tag, "_ready"}, 32'(ready3), 32'd1);
        @(posedge clk); #1;
        req3 = 1'b0;
        n = 0;
        while (valid3 !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_data"}, data3, ed);
        chk({tag, "_err"}, 32'(err3), 32'(ee));
    endtask

    initial begin
        logic [9:0] exp_r;
        logic [9:0] exp_v;
        int         nv;

        rst_n = 1'b0; req0 = 1'b0; req3 = 1'b0; we = 1'b0; uns = 1'b0;
        sz = 2'b00; addr = 32'd0; wdat = 32'd0;
        #12;
        chk("rst_ready0", 32'(ready0), 32'd1);
        chk("rst_valid0", 32'(valid0), 32'd0);
        chk("rst_data0", data0, 32'd0);
        chk("rst_err0", 32'(err0), 32'd0);
        chk("rst_ready3", 32'(ready3), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        acc0("st_w10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        acc0("ld_w10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        acc0("st_w10b", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0);
        acc0("st_b13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, 32'h0, 1'b0);
        acc0("ld_sb13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        acc0("ld_ub13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0);
        acc0("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80223344, 1'b0);
        acc0("ld_sh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8022, 1'b0);
        acc0("ld_uh10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00003344, 1'b0);
        acc0("ld_sb11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h00000033, 1'b0);
        acc0("ld_h11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
        acc0("ld_w12", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        acc0("st_w12", 1'b1, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
        acc0("st_h11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1);
        acc0("ld_w10d", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h80223344, 1'b0);
        acc0("ld_oor", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1);
        acc0("ld_sz11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        acc0("st_last", 1'b1, 2'b10, 1'b0, 32'hFFC, 32'h0BADF00D, 32'h0, 1'b0);
        acc0("ld_last", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 32'h0BADF00D, 1'b0);

        // Back-to-back loads on the zero-wait instance.
        @(negedge clk);
        we = 1'b0; sz = 2'b10; uns = 1'b0; addr = 32'h10; req0 = 1'b1;
        @(posedge clk); #1;
        sz = 2'b00; addr = 32'h13;
        chk("b2b_ready", 32'(ready0), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        chk("b2b_valid1", 32'(valid0), 32'd1);
        chk("b2b_data1", data0, 32'h80223344);
        @(posedge clk); #1;
        chk("b2b_valid2", 32'(valid0), 32'd1);
        chk("b2b_data2", data0, 32'hFFFFFF80);
        @(posedge clk); #1;
        chk("b2b_idle", 32'(valid0), 32'd0);
        chk("b2b_hold", data0, 32'hFFFFFF80);

        // Wait-state instance with req held: store accepted at edge 0, load at edge 4.
        exp_r = 10'b1110001000;
        exp_v = 10'b0100010000;
        @(negedge clk);
        we = 1'b1; sz = 2'b10; uns = 1'b0; addr = 32'h20; wdat = 32'hCAFEF00D; req3 = 1'b1;
        chk("ws_ready0", 32'(ready3), 32'd1);
        @(posedge clk); #1;
        we = 1'b0;
        chk("ws_r_e0", 32'(ready3), 32'd0);
        chk("ws_v_e0", 32'(valid3), 32'd0);
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk); #1;
            chk($sformatf("ws_r_e%0d", n), 32'(ready3), 32'(exp_r[n]));
            chk($sformatf("ws_v_e%0d", n), 32'(valid3), 32'(exp_v[n]));
            if (n == 4) chk("ws_st_data", data3, 32'h0);
            if (n == 8) chk("ws_ld_data", data3, 32'hCAFEF00D);
            if (n == 7) req3 = 1'b0;
        end

        // Reset pulse while a load is waiting.
        acc3("w_st24", 1'b1, 2'b10, 1'b0, 32'h24, 32'h5A5A5A5A, 32'h0, 1'b0);
        acc3("w_ld20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        we = 1'b0; sz = 2'b10; addr = 32'h24; req3 = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        chk("rw_inwait", 32'(ready3), 32'd0);
        rst_n = 1'b0;
        #2;
        chk("rw_rst_ready", 32'(ready3), 32'd1);
        chk("rw_rst_data", data3, 32'd0);
        rst_n = 1'b1;
        nv = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid3 === 1'b1) nv++;
        end
        chk("rw_novalid", 32'(nv), 32'd0);
        chk("rw_ready", 32'(ready3), 32'd1);
        chk("rw_data", data3, 32'd0);
        acc3("rw_ld24", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h5A5A5A5A, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Parametrised data memory for the MIPS datapath. It serves byte, halfword, word and (for 64-bit builds) doubleword loads and stores through a req/ready/valid handshake. Loads can be sign- or zero-extended. Latency is configurable, and the block flags misaligned and out-of-range accesses. It sits between the MEM stage and the on-chip data store, and it replaces the fixed single-cycle, word-only memory.

## Interface
- WIDTH, 32: data word width; legal values are 32 or 64. LANES = WIDTH/8; OFS = log2(LANES).
- DEPTH, 1024: number of WIDTH-bit words.
- WAIT_STATES, 0: extra cycles between acceptance and response; legal range is 0..7.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  1  request present.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 doubleword.
- unsigned_i  in  1  loads only; 1 = zero-extend, 0 = sign-extend.
- addr_i  in  32  byte address.
- data_i  in  WIDTH  store data, right-justified.
- ready_o  out  1  block can accept a request this cycle.
- valid_o  out  1  response strobe, one cycle per accepted request.
- data_o  out  WIDTH  load result, right-justified and extended.
- err_o  out  1  qualifies valid_o; the access was rejected.

## Operation
- Handshake: a request is accepted on a rising edge where req_i && ready_o. Requests are not queued; a request while ready_o=0 is ignored and must be held by the master.
- Address split: lane = addr_i[OFS-1:0]; index = addr_i >> OFS. Layout is little-endian: the byte at lane L occupies bits 8L+7:8L.
- Error conditions, evaluated at acceptance:
  - half with lane[0]≠0;
  - word with lane[1:0]≠0;
  - size 11 when WIDTH=32;
  - doubleword with lane≠0;
  - index ≥ DEPTH.
- On error: memory is untouched. The response carries err_o=1 and data_o=0.
- Store: written at the acceptance edge. Only the addressed lanes change: 1, 2, 4 or 8 bytes taken from the low bytes of data_i. The other lanes keep their values. The response carries data_o=0 and err_o=0.
- Load: the addressed lanes are read at the acceptance edge. The result is shifted down to bit 0 and extended to WIDTH per unsigned_i. A full-width access ignores unsigned_i.
- A load from a location written by an earlier accepted store returns the new data. There is no hazard window because the store commits at its acceptance edge.
- FSM states:
  - IDLE: ready_o=1. Acceptance goes to RESP if WAIT_STATES=0, otherwise to WAIT with cnt=WAIT_STATES-1.
  - WAIT: ready_o=0. Each cycle cnt decrements; at cnt=0 the next state is RESP.
  - RESP: valid_o=1 and ready_o=1. A new acceptance follows the same rules as in IDLE. With no acceptance the next state is IDLE.
- data_o and err_o are registered and hold their values until the next response. valid_o is the only strobe.
- Memory contents are not initialised and are not affected by reset.

## Timing
- Reset, asynchronous on rst_n=0: state=IDLE, cnt=0, ready_o=1, valid_o=0, data_o=0, err_o=0.
- Reset mid-operation: the pending response is dropped and no valid_o is issued for it. A store already accepted stays committed.
- Latency: a request accepted at edge k gives valid_o high for exactly the cycle following edge k+1+WAIT_STATES.
- Throughput with WAIT_STATES=0: one request per cycle. ready_o stays 1 in RESP, so back-to-back requests produce back-to-back valid_o pulses.
- Throughput with WAIT_STATES=W>0: one request per W+1 cycles. ready_o is 0 for W cycles after each acceptance.
- Erroring requests follow the same latency as good ones.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then word store of 0xDEADBEEF at 0x10, then word load at 0x10 with WAIT_STATES=0. Required: the load's valid_o is one cycle after its acceptance, data_o=0xDEADBEEF, err_o=0.
- Byte store of 0x80 at 0x13 over 0x11223344:
  - signed byte load at 0x13 → 0xFFFFFF80;
  - unsigned byte load at 0x13 → 0x00000080;
  - word load at 0x10 → 0x80223344.
- Half load at 0x11 and word load at 0x12. Required for both: valid_o with err_o=1, data_o=0, and the memory word unchanged.
- Load from index DEPTH (addr 0x1000 with DEPTH=1024) → err_o=1. Size 11 on a WIDTH=32 build → err_o=1.
- WAIT_STATES=3 with req_i held high:
  - ready_o is low for 3 cycles after each acceptance;
  - valid_o arrives 4 cycles after acceptance;
  - acceptances are spaced 4 cycles apart.
- Accept a load with WAIT_STATES=3, then pulse rst_n low during WAIT. Required: no valid_o; after reset ready_o=1 and data_o=0. A store accepted before the reset pulse reads back with its stored value.
